// File: rtl/fetch_unit.sv
// fetch_unit: holds the architectural PC, issues one word read per
// instruction to instruction memory, and presents the fetched word to
// execute until it retires. The PC only moves on retire, so a slow
// execute stage stalls fetch without any extra handshaking.
module fetch_unit #(
    parameter int unsigned          ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    // instruction memory read port
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    // decode/execute side
    output logic              instr_valid,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] pc_out,
    input  logic              instr_ready,
    input  logic [ADDR_W-1:0] next_pc,
    output logic              misalign_trap
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,   // request pulse for the word at pc
        S_WAIT  = 2'd1,   // waiting for memory, any latency
        S_VALID = 2'd2,   // presenting instr until execute retires it
        S_TRAP  = 2'd3    // misaligned next_pc seen; parked until reset
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q,    pc_d;
    logic [31:0]       instr_q, instr_d;
    logic              trap_q,  trap_d;

    logic              retire;
    logic              next_pc_aligned;

    assign retire          = (state_q == S_VALID) && instr_ready;
    assign next_pc_aligned = (next_pc[1:0] == 2'b00);

    // Next-state, PC and instruction capture logic
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        trap_d  = trap_q;
        unique case (state_q)
            S_FETCH: begin
                // Single-cycle request; memory answers no earlier than next cycle.
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // rvalid is only meaningful here; elsewhere it is a stale
                // or unrelated response and must not disturb instr.
                if (imem_rvalid) begin
                    instr_d = imem_rdata;
                    state_d = S_VALID;
                end
            end
            S_VALID: begin
                if (retire) begin
                    if (next_pc_aligned) begin
                        pc_d    = next_pc;
                        state_d = S_FETCH;
                    end else begin
                        // Keep pc pointing at the faulting instruction.
                        trap_d  = 1'b1;
                        state_d = S_TRAP;
                    end
                end
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // State registers; reset wins over every other input
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            trap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            trap_q  <= trap_d;
        end
    end

    // Gate the request with reset so nothing is issued while reset is held,
    // whatever state the FSM happened to be in.
    assign imem_req      = (state_q == S_FETCH) && !reset;
    assign imem_addr     = pc_q;
    assign instr_valid   = (state_q == S_VALID);
    assign instr         = instr_q;
    assign pc_out        = pc_q;
    assign misalign_trap = trap_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: cycle table for reset, sequential retire, execute stall
// and misaligned trap, then hand-written memory stall, self-loop,
// reset-mid-fetch and address wrap sequences.
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc_out;
    logic        instr_ready;
    logic [31:0] next_pc;
    logic        misalign_trap;

    int checks   = 0;
    int failures = 0;

    fetch_unit #(.ADDR_W(32), .RESET_PC(RPC)) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr        (instr),
        .pc_out       (pc_out),
        .instr_ready  (instr_ready),
        .next_pc      (next_pc),
        .misalign_trap(misalign_trap)
    );

    always #5 clk = ~clk;

    // One cycle: inputs for this cycle, outputs expected during it.
    typedef struct {
        logic        rst;
        logic        rvalid;
        logic [31:0] rdata;
        logic        ready;
        logic [31:0] npc;
        logic        chk;
        logic        e_req;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic        e_trap;
    } vec_t;

    vec_t tbl[23];

    function automatic vec_t mk(logic rst, logic rv, logic [31:0] rd, logic rdy,
                                logic [31:0] npc, logic chk, logic er, logic ev,
                                logic [31:0] ei, logic [31:0] ep, logic et);
        vec_t v;
        v.rst = rst; v.rvalid = rv; v.rdata = rd; v.ready = rdy; v.npc = npc;
        v.chk = chk; v.e_req = er; v.e_valid = ev; v.e_instr = ei;
        v.e_pc = ep; v.e_trap = et;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic er, input logic ev,
                              input logic [31:0] ei, input logic [31:0] ep, input logic et);
        check({tag, ".imem_req"}, 32'(imem_req), 32'(er));
        if (er) check({tag, ".imem_addr"}, imem_addr, ep);
        check({tag, ".instr_valid"}, 32'(instr_valid), 32'(ev));
        check({tag, ".instr"}, instr, ei);
        check({tag, ".pc_out"}, pc_out, ep);
        check({tag, ".misalign_trap"}, 32'(misalign_trap), 32'(et));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rst, input logic rv, input logic [31:0] rd,
                         input logic rdy, input logic [31:0] npc);
        reset = rst; imem_rvalid = rv; imem_rdata = rd; instr_ready = rdy; next_pc = npc;
        #1;
    endtask

    initial begin
        reset = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0; instr_ready = 1'b0; next_pc = '0;

        //              rst rv rdata         rdy npc           chk req vld instr         pc            trap
        tbl[0]  = mk(1, 0, 32'h0,        0, 32'h0,        0, 0, 0, 32'h0,        RPC,          0);
        tbl[1]  = mk(1, 0, 32'h0,        0, 32'h0,        1, 0, 0, 32'h0,        RPC,          0);
        tbl[2]  = mk(0, 0, 32'h0,        0, 32'h0,        1, 1, 0, 32'h0,        RPC,          0);
        tbl[3]  = mk(0, 1, 32'h00500093, 0, 32'h0,        1, 0, 0, 32'h0,        RPC,          0);
        tbl[4]  = mk(0, 0, 32'h0,        0, 32'h0,        1, 0, 1, 32'h00500093, RPC,          0);
        tbl[5]  = mk(0, 0, 32'h0,        1, 32'h1004,     1, 0, 1, 32'h00500093, RPC,          0);
        tbl[6]  = mk(0, 0, 32'h0,        0, 32'h0,        1, 1, 0, 32'h00500093, 32'h1004,     0);
        tbl[7]  = mk(0, 0, 32'h0,        1, 32'h1234,     1, 0, 0, 32'h00500093, 32'h1004,     0);
        tbl[8]  = mk(0, 1, 32'h00000013, 0, 32'h0,        1, 0, 0, 32'h00500093, 32'h1004,     0);
        tbl[9]  = mk(0, 1, 32'hDEADBEEF, 0, 32'h0,        1, 0, 1, 32'h00000013, 32'h1004,     0);
        tbl[10] = mk(0, 0, 32'h0,        1, 32'h2010,     1, 0, 1, 32'h00000013, 32'h1004,     0);
        tbl[11] = mk(0, 1, 32'hFFFFFFFF, 0, 32'h0,        1, 1, 0, 32'h00000013, 32'h2010,     0);
        tbl[12] = mk(0, 0, 32'h0,        0, 32'h0,        1, 0, 0, 32'h00000013, 32'h2010,     0);
        tbl[13] = mk(0, 1, 32'h00C00113, 0, 32'h0,        1, 0, 0, 32'h00000013, 32'h2010,     0);
        tbl[14] = mk(0, 0, 32'h0,        0, 32'h2014,     1, 0, 1, 32'h00C00113, 32'h2010,     0);
        tbl[15] = mk(0, 0, 32'h0,        0, 32'h3000,     1, 0, 1, 32'h00C00113, 32'h2010,     0);
        tbl[16] = mk(0, 0, 32'h0,        0, 32'h2013,     1, 0, 1, 32'h00C00113, 32'h2010,     0);
        tbl[17] = mk(0, 0, 32'h0,        0, 32'h0,        1, 0, 1, 32'h00C00113, 32'h2010,     0);
        tbl[18] = mk(0, 0, 32'h0,        1, 32'h2012,     1, 0, 1, 32'h00C00113, 32'h2010,     0);
        tbl[19] = mk(0, 1, 32'h12345678, 1, 32'h2020,     1, 0, 0, 32'h00C00113, 32'h2010,     1);
        tbl[20] = mk(0, 0, 32'h0,        0, 32'h0,        1, 0, 0, 32'h00C00113, 32'h2010,     1);
        tbl[21] = mk(1, 0, 32'h0,        0, 32'h0,        1, 0, 0, 32'h00C00113, 32'h2010,     1);
        tbl[22] = mk(0, 0, 32'h0,        0, 32'h0,        1, 1, 0, 32'h0,        RPC,          0);

        for (int i = 0; i < 23; i++) begin
            drive(tbl[i].rst, tbl[i].rvalid, tbl[i].rdata, tbl[i].ready, tbl[i].npc);
            if (tbl[i].chk)
                check_outs($sformatf("row%0d", i), tbl[i].e_req, tbl[i].e_valid,
                           tbl[i].e_instr, tbl[i].e_pc, tbl[i].e_trap);
            tick();
        end

        // Memory stall: request went out in the last table row; rvalid 5 cycles later.
        for (int c = 0; c < 4; c++) begin
            drive(0, 0, 32'h0, 0, 32'h0);
            check_outs($sformatf("mstall%0d", c), 0, 0, 32'h0, RPC, 0);
            tick();
        end
        drive(0, 1, 32'h00100073, 0, 32'h0);
        check_outs("mstall_rv", 0, 0, 32'h0, RPC, 0);
        tick();
        drive(0, 0, 32'h0, 0, 32'h0);
        check_outs("mstall_cap", 0, 1, 32'h00100073, RPC, 0);

        // Self-loop: next_pc == pc refetches the same address.
        drive(0, 0, 32'h0, 1, RPC);
        tick();
        drive(0, 0, 32'h0, 0, 32'h0);
        check_outs("selfloop", 1, 0, 32'h00100073, RPC, 0);
        tick();

        // Reset while in WAIT; response lands the cycle after reset drops.
        drive(1, 0, 32'h0, 0, 32'h0);
        tick();
        drive(0, 1, 32'hBADBAD00, 0, 32'h0);
        check_outs("rstmid_fetch", 1, 0, 32'h0, RPC, 0);
        tick();
        drive(0, 0, 32'h0, 0, 32'h0);
        check_outs("rstmid_wait0", 0, 0, 32'h0, RPC, 0);
        tick();
        check_outs("rstmid_wait1", 0, 0, 32'h0, RPC, 0);
        drive(0, 1, 32'h11111111, 0, 32'h0);
        tick();
        drive(0, 0, 32'h0, 0, 32'h0);
        check_outs("rstmid_cap", 0, 1, 32'h11111111, RPC, 0);

        // Address wrap: top word, then next_pc = 0.
        drive(0, 0, 32'h0, 1, 32'hFFFF_FFFC);
        tick();
        drive(0, 0, 32'h0, 0, 32'h0);
        check_outs("wrap_top", 1, 0, 32'h11111111, 32'hFFFF_FFFC, 0);
        tick();
        drive(0, 1, 32'h22222222, 0, 32'h0);
        tick();
        drive(0, 0, 32'h0, 1, 32'h0);
        check_outs("wrap_valid", 0, 1, 32'h22222222, 32'hFFFF_FFFC, 0);
        tick();
        drive(0, 0, 32'h0, 0, 32'h0);
        check_outs("wrap_zero", 1, 0, 32'h22222222, 32'h0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Sequential consumer of the next-PC value computed by program_counter, i.e. the other end of the next-PC interface.
- Holds the architectural PC register and issues word reads to instruction memory with a req/rvalid handshake.
- Presents each fetched instruction to decode/execute with a valid/ready handshake.
- Advances the PC to next_pc only when the current instruction retires, so a multi-cycle datapath stalls fetch naturally.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word aligned.
- ADDR_W, 32, PC / address width.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  one-cycle read request pulse to instruction memory.
- imem_addr  out  ADDR_W  read address; equals pc while imem_req=1.
- imem_rvalid  in  1  read data valid; earliest one cycle after imem_req.
- imem_rdata  in  32  instruction word, sampled when imem_rvalid=1.
- instr_valid  out  1  instr/pc_out hold a fetched, unretired instruction.
- instr  out  32  registered instruction word.
- pc_out  out  ADDR_W  PC of the instruction being presented, fed to program_counter pc_in.
- instr_ready  in  1  execute retires the presented instruction this cycle.
- next_pc  in  ADDR_W  next PC from program_counter, sampled on retire.
- misalign_trap  out  1  sticky; next_pc was not word aligned at retire.

Behaviour:
- Reset (synchronous, active-high; overrides every other input, including mid-fetch): state=FETCH, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0, misalign_trap=0. An imem_rvalid arriving in the cycle after reset is ignored.
- States: FETCH, WAIT, VALID, TRAP. One-hot or binary encoding is implementation choice.
- FETCH:
  - imem_req=1, imem_addr=pc, for exactly one cycle.
  - Next state is WAIT.
- WAIT:
  - imem_req=0; stays in WAIT while imem_rvalid=0. No timeout.
  - On imem_rvalid=1: instr<=imem_rdata, state<=VALID.
  - instr_valid goes high the cycle after rvalid (registered).
  - imem_rvalid in any state other than WAIT is ignored.
- VALID:
  - instr_valid=1; instr and pc_out stable until retire.
  - Retire is instr_valid & instr_ready.
  - On retire with next_pc[1:0]==0: pc<=next_pc, instr_valid<=0, state<=FETCH.
  - On retire with next_pc[1:0]!=0: pc unchanged, instr_valid<=0, misalign_trap<=1, state<=TRAP.
  - instr_ready while instr_valid=0 has no effect.
- TRAP: no requests, instr_valid=0, misalign_trap=1. Leaves TRAP only via reset.
- Latency:
  - Minimum fetch-to-valid is 3 cycles: req in cycle N, rvalid in N+1, instr_valid in N+2.
  - Minimum retire-to-next-req is 1 cycle.
- pc_out=pc at all times, combinationally.
- next_pc arithmetic is done entirely by program_counter; this block adds nothing to it.
- Back-to-back retires are impossible; instr_valid always drops for at least the FETCH and WAIT cycles.
- next_pc==pc (self-loop) is legal and refetches the same address.
- Address wrap from 32'hFFFF_FFFC to 0 is accepted as provided by program_counter.

Test Plan:
1. Reset with RESET_PC=32'h1000 → cycle after reset: imem_req=1, imem_addr=32'h1000. Memory returns 32'h00500093 one cycle later → instr_valid=1, instr=32'h00500093, pc_out=32'h1000.
2. Sequential retire: instr_ready=1, next_pc=32'h1004 → instr_valid drops next cycle, following cycle imem_req=1 with imem_addr=32'h1004.
3. Memory stall: rvalid delayed 5 cycles after req → FSM stays in WAIT, imem_req=0 throughout, instr_valid=0. Data then captured correctly.
4. Execute stall: instr_ready held 0 for 4 cycles while next_pc changes → instr, pc_out and instr_valid stable, no new imem_req. Retire with next_pc=32'h2010 → next fetch address is 32'h2010.
5. Misaligned jump: retire with next_pc=32'h2012 → misalign_trap=1 and sticky, no further imem_req, pc_out stays 32'h2010. Reset clears misalign_trap and fetches from RESET_PC.
6. Reset mid-fetch: assert reset in WAIT, with rvalid arriving the cycle after deassert → rdata is ignored, fresh req goes to RESET_PC, instr_valid stays 0 until that fetch's rvalid.
